// File: rtl/solitaire_move_driver_pkg.sv
// Shared types for the peg solitaire move driver and board engine.
package solitaire_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RES_ACCEPTED  = 2'd0,
    RES_ILLEGAL   = 2'd1,
    RES_GAME_OVER = 2'd2,
    RES_BAD_COORD = 2'd3
  } res_code_t;

  // No engine square sits at 7, so parking here guarantees a no-op.
  localparam logic [2:0] PARK_COORD = 3'd7;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    dir_t       dir;
  } move_cmd_t;

  function automatic logic coord_ok(input move_cmd_t c, input logic [3:0] width);
    return ({1'b0, c.x} < width) && ({1'b0, c.y} < width);
  endfunction

endpackage

// File: rtl/solitaire_move_driver_if.sv
// Move command valid/ready stream from the user-input front end.
interface solitaire_move_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_x;
  logic [2:0] cmd_y;
  logic [1:0] cmd_dir;

  modport master (output cmd_valid, cmd_x, cmd_y, cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_dir, output cmd_ready);
endinterface

// File: rtl/solitaire_move_driver_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit for full/empty.
module solitaire_move_fifo
  import solitaire_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  move_cmd_t wdata,
  input  logic      pop,
  output move_cmd_t rdata,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  move_cmd_t   mem_q [DEPTH];
  move_cmd_t   mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/solitaire_move_driver.sv
// Buffers move commands, issues each to the board engine for one cycle,
// and infers the outcome from the engine's piece count.
module solitaire_move_driver
  import solitaire_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BOARD_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  solitaire_move_driver_if.slave  cmd_if,
  output logic [2:0]              piece_x,
  output logic [2:0]              piece_y,
  output logic [1:0]              direction,
  input  logic [5:0]              piece_count,
  input  logic                    game_over,
  output logic                    res_valid,
  output logic [1:0]              res_code,
  output logic [5:0]              moves_done,
  output logic [7:0]              rejects
);
  localparam logic [3:0] BW = 4'(BOARD_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_REPORT} state_t;

  state_t     state_q;
  logic [2:0] piece_x_q, piece_y_q;
  dir_t       dir_q;
  logic [5:0] cnt_snap_q;
  logic       res_valid_q;
  res_code_t  res_code_q;
  logic [5:0] moves_q;
  logic [7:0] rejects_q;

  move_cmd_t  in_cmd, head;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign in_cmd           = '{x: cmd_if.cmd_x, y: cmd_if.cmd_y, dir: dir_t'(cmd_if.cmd_dir)};
  assign cmd_if.cmd_ready = !fifo_full;
  assign fifo_push        = cmd_if.cmd_valid && !fifo_full;
  assign fifo_pop         = (state_q == S_IDLE) && !fifo_empty;

  solitaire_move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_cmd),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Engine-facing outputs default to park every cycle; only the IDLE->ISSUE
  // transition loads a real square, so they hold it for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      piece_x_q   <= PARK_COORD;
      piece_y_q   <= PARK_COORD;
      dir_q       <= DIR_LEFT;
      cnt_snap_q  <= '0;
      res_valid_q <= 1'b0;
      res_code_q  <= RES_ACCEPTED;
      moves_q     <= '0;
      rejects_q   <= '0;
    end else begin
      piece_x_q   <= PARK_COORD;
      piece_y_q   <= PARK_COORD;
      dir_q       <= DIR_LEFT;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (!fifo_empty) begin
          if (!coord_ok(head, BW)) begin
            res_code_q  <= RES_BAD_COORD;
            res_valid_q <= 1'b1;
            state_q     <= S_REPORT;
          end else if (game_over) begin
            res_code_q  <= RES_GAME_OVER;
            res_valid_q <= 1'b1;
            state_q     <= S_REPORT;
          end else begin
            piece_x_q <= head.x;
            piece_y_q <= head.y;
            dir_q     <= head.dir;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_snap_q <= piece_count;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          // A legal jump removes exactly one peg.
          if (piece_count == cnt_snap_q - 6'd1) begin
            res_code_q <= RES_ACCEPTED;
            moves_q    <= moves_q + 6'd1;
          end else begin
            res_code_q <= RES_ILLEGAL;
          end
          res_valid_q <= 1'b1;
          state_q     <= S_REPORT;
        end
        S_REPORT: begin
          if (res_code_q != RES_ACCEPTED && rejects_q != 8'hFF)
            rejects_q <= rejects_q + 8'd1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign piece_x    = piece_x_q;
  assign piece_y    = piece_y_q;
  assign direction  = dir_q;
  assign res_valid  = res_valid_q;
  assign res_code   = res_code_q;
  assign moves_done = moves_q;
  assign rejects    = rejects_q;
endmodule

// File: tb/tb_solitaire_move_driver.sv
// Directed bench for solitaire_move_driver with a small English-board engine model.
module tb_solitaire_move_driver;
  import solitaire_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] piece_x, piece_y;
  logic [1:0] direction;
  logic [5:0] piece_count;
  logic       game_over;
  logic       res_valid;
  logic [1:0] res_code;
  logic [5:0] moves_done;
  logic [7:0] rejects;

  always #5 clk = ~clk;

  solitaire_move_driver_if ifc();

  solitaire_move_driver dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_if      (ifc.slave),
    .piece_x     (piece_x),
    .piece_y     (piece_y),
    .direction   (direction),
    .piece_count (piece_count),
    .game_over   (game_over),
    .res_valid   (res_valid),
    .res_code    (res_code),
    .moves_done  (moves_done),
    .rejects     (rejects)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Engine model: English cross board, centre empty, 32 pegs.
  bit board [7][7];
  int cnt;
  assign piece_count = 6'(cnt);

  function automatic bit on_board(input int x, input int y);
    return x >= 0 && x < 7 && y >= 0 && y < 7 && !((x < 2 || x > 4) && (y < 2 || y > 4));
  endfunction

  always @(posedge clk) begin : engine
    int x, y, dx, dy;
    x = int'(piece_x); y = int'(piece_y); dx = 0; dy = 0;
    case (direction)
      2'd0: dx = -1;
      2'd1: dx = 1;
      2'd2: dy = -1;
      default: dy = 1;
    endcase
    if (on_board(x, y) && on_board(x+dx, y+dy) && on_board(x+2*dx, y+2*dy) &&
        board[y][x] && board[y+dy][x+dx] && !board[y+2*dy][x+2*dx]) begin
      board[y][x]             <= 1'b0;
      board[y+dy][x+dx]       <= 1'b0;
      board[y+2*dy][x+2*dx]   <= 1'b1;
      cnt                     <= cnt - 1;
    end
  end

  // Monitor: result pulses and cycles where the engine sees a real square.
  int cyc = 0;
  int issue_cnt = 0;
  int res_codes[$];
  int res_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (res_valid) begin
      res_codes.push_back(int'(res_code));
      res_cyc.push_back(cyc);
    end
    if (piece_x != 3'd7 || piece_y != 3'd7) issue_cnt <= issue_cnt + 1;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int x, input int y, input int d);
    int g;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_x = 3'(x); ifc.cmd_y = 3'(y); ifc.cmd_dir = 2'(d);
    g = 0;
    while (!ifc.cmd_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("push_timeout", 0, 1);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, n0, g;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++) board[y][x] = on_board(x, y);
    board[3][3] = 1'b0;
    cnt = 32;
    rst = 1'b1; game_over = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.cmd_x = '0; ifc.cmd_y = '0; ifc.cmd_dir = '0;
    repeat (2) @(negedge clk);
    chk("rst_px", piece_x, 7);
    chk("rst_py", piece_y, 7);
    chk("rst_dir", direction, 0);
    chk("rst_ready", ifc.cmd_ready, 1);
    chk("rst_rv", res_valid, 0);
    chk("rst_rc", res_code, 0);
    chk("rst_moves", moves_done, 0);
    chk("rst_rej", rejects, 0);
    rst = 1'b0;
    @(negedge clk);

    // Legal opening jump (3,5) UP into the centre.
    push(3, 5, 2);
    @(negedge clk);
    chk("t1_issue_px", piece_x, 3);
    chk("t1_issue_py", piece_y, 5);
    chk("t1_issue_dir", direction, 2);
    @(negedge clk);
    chk("t1_check_px", piece_x, 7);
    chk("t1_check_rv", res_valid, 0);
    @(negedge clk);
    chk("t1_rv", res_valid, 1);
    chk("t1_rc", res_code, 0);
    chk("t1_cnt", piece_count, 31);
    chk("t1_moves", moves_done, 1);
    @(negedge clk);
    chk("t1_rej", rejects, 0);

    // Replay: origin now empty.
    push(3, 5, 2);
    repeat (3) @(negedge clk);
    chk("t2_rv", res_valid, 1);
    chk("t2_rc", res_code, 1);
    chk("t2_moves", moves_done, 1);
    chk("t2_cnt", piece_count, 31);
    @(negedge clk);
    chk("t2_rej", rejects, 1);

    // Out-of-range coordinate: reported 1 cycle after pop, never issued.
    ic = issue_cnt;
    push(7, 2, 0);
    @(negedge clk);
    chk("t3_rv", res_valid, 1);
    chk("t3_rc", res_code, 3);
    @(negedge clk);
    chk("t3_rej", rejects, 2);
    chk("t3_noissue", issue_cnt, ic);

    // Six back-to-back commands.
    n0 = res_codes.size();
    push(5, 4, 0);
    push(0, 0, 1);
    push(7, 7, 3);
    push(3, 2, 3);
    push(3, 6, 2);
    chk("t4_ready_full", ifc.cmd_ready, 0);
    push(4, 2, 3);
    g = 0;
    while (res_codes.size() < n0 + 6 && g < 80) begin
      @(negedge clk);
      g++;
    end
    chk("t4_nres", res_codes.size(), n0 + 6);
    if (res_codes.size() >= n0 + 6) begin
      chk("t4_rc0", res_codes[n0],   0);
      chk("t4_rc1", res_codes[n0+1], 1);
      chk("t4_rc2", res_codes[n0+2], 3);
      chk("t4_rc3", res_codes[n0+3], 1);
      chk("t4_rc4", res_codes[n0+4], 1);
      chk("t4_rc5", res_codes[n0+5], 0);
      chk("t4_gap", res_cyc[n0+1] - res_cyc[n0], 4);
    end
    @(negedge clk);
    chk("t4_moves", moves_done, 3);
    chk("t4_rej", rejects, 6);
    chk("t4_cnt", piece_count, 29);

    // Game over: rejected at pop, never issued.
    game_over = 1'b1;
    ic = issue_cnt;
    push(3, 1, 3);
    @(negedge clk);
    chk("t5_rv", res_valid, 1);
    chk("t5_rc", res_code, 2);
    @(negedge clk);
    chk("t5_rej", rejects, 7);
    chk("t5_noissue", issue_cnt, ic);
    chk("t5_cnt", piece_count, 29);
    game_over = 1'b0;

    // Reset during the second ISSUE with two commands still queued.
    push(3, 1, 3);
    push(2, 3, 1);
    push(0, 0, 1);
    push(1, 1, 0);
    g = 0;
    while (piece_x == 3'd7 && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("t6_issue_px", piece_x, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_px", piece_x, 7);
    chk("t6_py", piece_y, 7);
    chk("t6_ready", ifc.cmd_ready, 1);
    chk("t6_rv", res_valid, 0);
    chk("t6_moves", moves_done, 0);
    chk("t6_rej", rejects, 0);
    n0 = res_codes.size();
    ic = issue_cnt;
    repeat (20) @(negedge clk);
    chk("t6_nores", res_codes.size(), n0);
    chk("t6_noissue", issue_cnt, ic);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/solitaire_move_driver.md
Name: solitaire_move_driver

Overview:
- Initiator for the peg solitaire board engine: accepts move commands on a valid/ready stream, buffers them, and drives the engine's piece_x/piece_y/direction inputs for exactly one cycle per move.
- Infers accept or reject from the engine's piece_count and reports a per-move result code.
- Sits between the user-input front end and the board engine at top level.

Parameters:
- FIFO_DEPTH, 4, command buffer entries; power of two, minimum 2.
- BOARD_WIDTH, 7, board edge length; the park coordinate is 7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_x  in  3  piece column
- cmd_y  in  3  piece row
- cmd_dir  in  2  direction code: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN
- piece_x  out  3  to engine
- piece_y  out  3  to engine
- direction  out  2  to engine
- piece_count  in  6  from engine
- game_over  in  1  from engine
- res_valid  out  1  one-cycle result pulse
- res_code  out  2  0 ACCEPTED, 1 ILLEGAL, 2 GAME_OVER, 3 BAD_COORD
- moves_done  out  6  accepted-move counter
- rejects  out  8  rejected-move counter, saturating

Behaviour:
- Reset values:
  - piece_x = piece_y = 7 (park), direction = 0.
  - cmd_ready = 1, res_valid = 0, res_code = 0.
  - moves_done = 0, rejects = 0.
  - FIFO empty, FSM in IDLE.
- Reset mid-operation discards the in-flight move and all buffered commands. No result pulse is emitted for them.
- Park: whenever the FSM is not in ISSUE, piece_x and piece_y are 7. No engine square matches 7, so the engine makes no move. All engine-facing outputs are registered.
- FIFO:
  - cmd_ready = !full. No combinational path from cmd_valid to cmd_ready.
  - Push and pop in the same cycle are both performed, including when full (pop frees the slot, but ready was already low, so no push occurs).
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- FSM (states IDLE, ISSUE, CHECK, REPORT):
  - IDLE: if the FIFO is non-empty, pop the head into the cmd register.
    - If head x>6 or y>6: go to REPORT with BAD_COORD.
    - Else if game_over=1 this cycle: go to REPORT with GAME_OVER.
    - Else: go to ISSUE.
  - ISSUE (1 cycle): drive piece_x/piece_y/direction = cmd, and snapshot piece_count into cnt_snap. The engine commits on the closing edge. Go to CHECK.
  - CHECK (1 cycle): outputs are parked.
    - piece_count == cnt_snap-1 (6-bit): ACCEPTED, moves_done += 1.
    - Otherwise: ILLEGAL.
    - Go to REPORT.
  - REPORT (1 cycle): res_valid=1 with the code, and rejects += 1 for any non-ACCEPTED code (saturates at 255). Go to IDLE.
- Latency: from pop to res_valid is 3 cycles for an issued move and 1 cycle for a BAD_COORD or GAME_OVER rejection. Sustained throughput is one move per 4 cycles.
- moves_done wraps modulo 64; in practice it never exceeds 31.
- Out-of-board squares with in-range coordinates (e.g. 0,0) are issued normally; the engine rejects them, giving ILLEGAL.
- Commands are processed strictly in FIFO order.

Decomposition:
- solitaire_pkg:
  - dir_t enum (LEFT=0, RIGHT=1, UP=2, DOWN=3), shared with the engine.
  - res_code_t enum.
  - PARK_COORD = 3'd7.
  - move_cmd_t packed struct {x, y, dir} (8 bits).
- Sub-module solitaire_move_fifo: parameterised synchronous FIFO of move_cmd_t with push/pop/full/empty.

Test Plan:
- Reset, then push (3,5,UP) with the engine at its initial board: ISSUE cycle shows piece_x=3, piece_y=5, direction=2; res_code=ACCEPTED 3 cycles after pop; piece_count 32→31; moves_done=1.
- Replay the same move (3,5,UP): res_code=ILLEGAL, moves_done stays 1, rejects=1, piece_count stays 31.
- Push (7,2,LEFT): res_code=BAD_COORD 1 cycle after pop; piece_x never leaves 7.
- Push 6 commands back-to-back with no gaps: cmd_ready drops after the 4th is buffered (one already popped); all 6 commands yield results in order, one every 4 cycles.
- Force game_over=1 and push (3,1,DOWN): res_code=GAME_OVER; piece_x/piece_y stay at 7 throughout.
- Assert rst during ISSUE with 2 commands queued: next cycle outputs are parked, cmd_ready=1, res_valid=0, and no later result pulses appear.
